// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcode encodings (common to
// the alu, the decoder and the arbiter), arbiter FSM state type and the
// opcode-support predicate.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0011;
    localparam logic [OP_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [OP_W-1:0] ALU_EQ  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // True for opcodes the alu implements; anything else is reported as an
    // error to the requester.
    function automatic logic alu_op_supported(input logic [OP_W-1:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_EQ: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
// Ports:
//   valid    [1:0] requesters with a pending operation
//   prio           requester that wins when both are valid
//   grant    [1:0] one-hot winner, 00 when nobody is valid
//   grant_id       index of the winner (0 when nobody is valid)
module rr_arbiter2
    import alu_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant_id = 1'b0;
        case (valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = prio;
            default: grant_id = 1'b0;
        endcase
    end

    always_comb begin
        grant = '0;
        if (valid != 2'b00) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between two requesters (0: main datapath,
// 1: auxiliary unit). Round-robin grant, one operation in flight, operands
// registered into the alu, result captured into a response register that is
// held until the owning requester takes it. Unsupported opcodes come back
// with rsp_err=1 and rsp_data=0.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   per-requester request handshake
//   req_srca/srcb/op      packed payloads, requester 0 in the low half
//   rsp_valid/rsp_ready   per-requester response handshake (rsp_valid one-hot)
//   rsp_data, rsp_err     captured result and unsupported-op flag
//   alu_srca/srcb/op      registered operands to the alu
//   alu_result            combinational result from the alu
//   busy                  an operation is in flight or awaiting retirement
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [2*DATA_WIDTH-1:0]      req_srca,
    input  logic [2*DATA_WIDTH-1:0]      req_srcb,
    input  logic [2*OPCODE_LENGTH-1:0]   req_op,
    output logic [1:0]                   rsp_valid,
    input  logic [1:0]                   rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_err,
    output logic [DATA_WIDTH-1:0]        alu_srca,
    output logic [DATA_WIDTH-1:0]        alu_srcb,
    output logic [OPCODE_LENGTH-1:0]     alu_op,
    input  logic [DATA_WIDTH-1:0]        alu_result,
    output logic                         busy
);

    arb_state_t                 state;
    logic                       prio;
    logic                       owner;
    logic [DATA_WIDTH-1:0]      srca_q;
    logic [DATA_WIDTH-1:0]      srcb_q;
    logic [OPCODE_LENGTH-1:0]   op_q;

    logic [1:0]                 grant;
    logic                       grant_id;

    rr_arbiter2 u_rr (
        .valid    (req_valid),
        .prio     (prio),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Only IDLE offers ready; grant is already masked by req_valid.
    assign req_ready = (state == IDLE) ? grant : 2'b00;
    assign busy      = (state != IDLE);

    // Operand registers feed the alu directly, so the alu inputs are stable
    // for the whole EXEC cycle and read as zero after reset.
    assign alu_srca = srca_q;
    assign alu_srcb = srcb_q;
    assign alu_op   = op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            owner     <= 1'b0;
            srca_q    <= '0;
            srcb_q    <= '0;
            op_q      <= '0;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        owner <= grant_id;
                        prio  <= ~grant_id;
                        if (grant_id) begin
                            srca_q <= req_srca[2*DATA_WIDTH-1:DATA_WIDTH];
                            srcb_q <= req_srcb[2*DATA_WIDTH-1:DATA_WIDTH];
                            op_q   <= req_op[2*OPCODE_LENGTH-1:OPCODE_LENGTH];
                        end else begin
                            srca_q <= req_srca[DATA_WIDTH-1:0];
                            srcb_q <= req_srcb[DATA_WIDTH-1:0];
                            op_q   <= req_op[OPCODE_LENGTH-1:0];
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (alu_op_supported(op_q)) begin
                        rsp_data <= alu_result;
                        rsp_err  <= 1'b0;
                    end else begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    // rsp_data is left as-is on retirement.
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural alu attached to the
// alu_* ports. Unsupported opcodes make the model return a non-zero pattern so
// the arbiter's zeroing of rsp_data is observable.
module tb_alu_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned OW = 4;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_srca;
    logic [2*DW-1:0] req_srcb;
    logic [2*OW-1:0] req_op;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic [DW-1:0]   alu_srca;
    logic [DW-1:0]   alu_srcb;
    logic [OW-1:0]   alu_op;
    logic [DW-1:0]   alu_result;
    logic            busy;

    alu_arbiter #(
        .DATA_WIDTH    (DW),
        .OPCODE_LENGTH (OW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_srca   (req_srca),
        .req_srcb   (req_srcb),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_srca & alu_srcb;
            4'b0001: alu_result = alu_srca | alu_srcb;
            4'b0010: alu_result = alu_srca + alu_srcb;
            4'b0011: alu_result = alu_srca - alu_srcb;
            4'b0100: alu_result = alu_srca ^ alu_srcb;
            4'b1000: alu_result = {31'b0, (alu_srca == alu_srcb)};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic        err;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    int checks_total = 0;
    int checks_passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [1:0] onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
        if (id) begin
            req_srca[63:32] = a;
            req_srcb[63:32] = b;
            req_op[7:4]     = op;
        end else begin
            req_srca[31:0] = a;
            req_srcb[31:0] = b;
            req_op[3:0]    = op;
        end
    endtask

    task automatic push_exp(input logic owner, input logic [31:0] data, input logic err);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic compare_rsp(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_unexpected"}, 64'(rsp_valid), 64'(2'b00));
        end else begin
            e = sb.pop_front();
            check({name, "_valid"}, 64'(rsp_valid), 64'(onehot(e.owner)));
            check({name, "_data"},  64'(rsp_data),  64'(e.data));
            check({name, "_err"},   64'(rsp_err),   64'(e.err));
        end
    endtask

    task automatic wait_ready(input logic id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        @(posedge clk); #1;
        drive(v.id, v.a, v.b, v.op);
        req_valid[v.id] = 1'b1;
        wait_ready(v.id, ok);
        if (ok) begin
            check("vec_req_ready", 64'(req_ready), 64'(onehot(v.id)));
            push_exp(v.id, v.exp_data, v.exp_err);
            @(posedge clk); #1;
            req_valid = 2'b00;
            @(negedge clk);
            check("vec_exec_busy",  64'(busy),      64'(1));
            check("vec_exec_rspv",  64'(rsp_valid), 64'(2'b00));
            check("vec_exec_aluop", 64'(alu_op),    64'(v.op));
            check("vec_exec_srca",  64'(alu_srca),  64'(v.a));
            check("vec_exec_srcb",  64'(alu_srcb),  64'(v.b));
            @(negedge clk);
            compare_rsp("vec_rsp");
            rsp_ready = onehot(v.id);
            @(posedge clk); #1;
            rsp_ready = 2'b00;
            @(negedge clk);
            check("vec_retire_rspv", 64'(rsp_valid), 64'(2'b00));
            check("vec_retire_busy", 64'(busy),      64'(0));
        end else begin
            req_valid = 2'b00;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit    ok;
        int    accepts;
        int    cyc;
        int    last_acc;
        int    nrsp;
        logic  exp_winner;

        vecs[0] = '{1'b0, 32'd5,          32'd7,          4'b0010, 32'd12,         1'b0};
        vecs[1] = '{1'b1, 32'd3,          32'd5,          4'b0101, 32'd0,          1'b1};
        vecs[2] = '{1'b1, 32'd9,          32'd9,          4'b1000, 32'd1,          1'b0};
        vecs[3] = '{1'b0, 32'h0000_00A0,  32'h0000_0005,  4'b0001, 32'h0000_00A5,  1'b0};
        vecs[4] = '{1'b1, 32'hFF00_FF00,  32'h0FF0_0FF0,  4'b0100, 32'hF0F0_F0F0,  1'b0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd2,          4'b0010, 32'd1,          1'b0};
        vecs[6] = '{1'b0, 32'd4,          32'd4,          4'b1111, 32'd0,          1'b1};
        vecs[7] = '{1'b1, 32'd1,          32'd2,          4'b1000, 32'd0,          1'b0};
        vecs[8] = '{1'b0, 32'd0,          32'd1,          4'b0011, 32'hFFFF_FFFF,  1'b0};

        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_srca = '0;
        req_srcb = '0;
        req_op = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'(2'b00));
        check("rst_rsp_data",  64'(rsp_data),  64'(0));
        check("rst_rsp_err",   64'(rsp_err),   64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_alu_srca",  64'(alu_srca),  64'(0));
        check("rst_alu_srcb",  64'(alu_srcb),  64'(0));
        check("rst_alu_op",    64'(alu_op),    64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 64'(req_ready), 64'(2'b00));

        // Single-requester table
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Both held valid: strict alternation starting from requester 0
        do_reset();
        @(posedge clk); #1;
        drive(1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0000);
        drive(1'b1, 32'd3, 32'd5, 4'b0011);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        exp_winner = 1'b0;
        accepts = 0;
        cyc = 0;
        last_acc = 0;
        while ((accepts < 6 || sb.size() != 0) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid != 2'b00) compare_rsp("alt_rsp");
            if (req_ready != 2'b00) begin
                check("alt_grant", 64'(req_ready), 64'(onehot(exp_winner)));
                if (accepts > 0) check("alt_gap", 64'(cyc - last_acc), 64'(3));
                last_acc = cyc;
                if (exp_winner) push_exp(1'b1, 32'hFFFF_FFFE, 1'b0);
                else            push_exp(1'b0, 32'h0000_00F0, 1'b0);
                exp_winner = ~exp_winner;
                accepts++;
            end
            @(posedge clk); #1;
            if (accepts == 6) req_valid = 2'b00;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        check("alt_accepts", 64'(accepts), 64'(6));
        check("alt_drained", 64'(sb.size()), 64'(0));
        sb.delete();

        // Response backpressure, with both requesters waiting
        @(posedge clk); #1;
        drive(1'b0, 32'd100, 32'd23, 4'b0010);
        drive(1'b1, 32'd7, 32'd7, 4'b1000);
        req_valid = 2'b01;
        wait_ready(1'b0, ok);
        if (ok) begin
            push_exp(1'b0, 32'd123, 1'b0);
            @(posedge clk); #1;
            req_valid = 2'b00;
            @(negedge clk);
            @(negedge clk);
            compare_rsp("bp_first");
            req_valid = 2'b11;
            rsp_ready = 2'b10;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("bp_rsp_valid", 64'(rsp_valid), 64'(2'b01));
                check("bp_rsp_data",  64'(rsp_data),  64'(123));
                check("bp_rsp_err",   64'(rsp_err),   64'(0));
                check("bp_req_ready", 64'(req_ready), 64'(2'b00));
                check("bp_busy",      64'(busy),      64'(1));
            end
            rsp_ready = 2'b01;
            @(posedge clk); #1;
            rsp_ready = 2'b00;
            req_valid = 2'b00;
            @(negedge clk);
            check("bp_release_rspv", 64'(rsp_valid), 64'(2'b00));
            check("bp_release_busy", 64'(busy),      64'(0));
        end
        req_valid = 2'b00;

        // Asynchronous reset in EXEC drops the op and clears prio
        @(posedge clk); #1;
        drive(1'b0, 32'h0000_1000, 32'h0000_0234, 4'b0010);
        req_valid = 2'b01;
        wait_ready(1'b0, ok);
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",      64'(busy),      64'(0));
        check("arst_rsp_valid", 64'(rsp_valid), 64'(2'b00));
        check("arst_rsp_data",  64'(rsp_data),  64'(0));
        check("arst_rsp_err",   64'(rsp_err),   64'(0));
        check("arst_alu_srca",  64'(alu_srca),  64'(0));
        check("arst_alu_srcb",  64'(alu_srcb),  64'(0));
        check("arst_alu_op",    64'(alu_op),    64'(0));
        check("arst_req_ready", 64'(req_ready), 64'(2'b00));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 32'd5, 32'd3, 4'b0100);
        drive(1'b1, 32'd1, 32'd1, 4'b0010);
        req_valid = 2'b11;
        @(negedge clk);
        check("arst_prio_grant", 64'(req_ready), 64'(2'b01));
        push_exp(1'b0, 32'd6, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        nrsp = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                compare_rsp("arst_rsp");
                nrsp++;
                rsp_ready = rsp_valid;
            end
            @(posedge clk); #1;
            rsp_ready = 2'b00;
        end
        check("arst_rsp_count", 64'(nrsp), 64'(1));
        check("arst_drained",   64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
